// File: rtl/streampf_dma_sched.sv
// Shares the single cache DMA channel between demand misses and one buffered stream prefetch.
// Optional prefetch aging is enabled by defining STREAMPF_SCHED_AGING_EN.
module streampf_dma_sched #(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned max_wait_p   = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    demand_v_i,
    input  logic [addr_width_p-1:0] demand_addr_i,
    output logic                    demand_yumi_o,
    input  logic                    pf_v_i,
    input  logic [addr_width_p-1:0] pf_addr_i,
    output logic                    pf_ready_o,
    output logic                    dma_v_o,
    output logic [addr_width_p-1:0] dma_addr_o,
    output logic                    dma_pf_o,
    input  logic                    dma_ready_i,
    input  logic                    dma_done_i,
    output logic                    dma_busy_o,
    output logic                    pf_drop_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    if (max_wait_p == 0) begin : g_bad_max_wait
        $error("max_wait_p must be at least 1");
    end

    state_e                  state_r;
    logic                    slot_v_r;
    logic [addr_width_p-1:0] slot_addr_r;
    logic [addr_width_p-1:0] req_addr_r;
    logic                    req_pf_r;

    logic accept_demand;
    logic supersede;
    logic dequeue;
    logic slot_write;
    logic age_drop;

    // Handshake decode; the reset gate keeps the combinational pulses quiet while reset is held.
    assign accept_demand = (state_r == IDLE) & demand_v_i & ~reset_i;
    assign supersede     = accept_demand & slot_v_r & (slot_addr_r == demand_addr_i);
    assign dequeue       = (state_r == IDLE) & ~demand_v_i & slot_v_r & ~reset_i;
    assign slot_write    = pf_v_i & ~slot_v_r;

`ifdef STREAMPF_SCHED_AGING_EN
    localparam int unsigned AgeW = (max_wait_p < 2) ? 1 : $clog2(max_wait_p + 1);
    logic [AgeW-1:0] slot_age_r;

    // Drop on the cycle the age would reach max_wait_p; dequeue and supersede win.
    assign age_drop = slot_v_r & ~supersede & ~dequeue & ~reset_i
                    & (slot_age_r == AgeW'(max_wait_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_age_r <= '0;
        end else if (slot_write) begin
            slot_age_r <= '0;
        end else if (slot_v_r && !supersede && !dequeue && !age_drop) begin
            slot_age_r <= slot_age_r + AgeW'(1);
        end
    end
`else
    assign age_drop = 1'b0;
`endif

    assign demand_yumi_o = accept_demand;
    assign pf_drop_o     = supersede | age_drop;
    assign pf_ready_o    = ~slot_v_r;
    assign dma_v_o       = (state_r == REQ);
    assign dma_busy_o    = (state_r != IDLE);
    assign dma_addr_o    = req_addr_r;
    assign dma_pf_o      = req_pf_r;

    // Channel FSM plus prefetch slot; a write only lands in an empty slot, so it never races a clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            req_addr_r  <= '0;
            req_pf_r    <= 1'b0;
            slot_v_r    <= 1'b0;
            slot_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_demand) begin
                        req_addr_r <= demand_addr_i;
                        req_pf_r   <= 1'b0;
                        state_r    <= REQ;
                    end else if (dequeue) begin
                        req_addr_r <= slot_addr_r;
                        req_pf_r   <= 1'b1;
                        state_r    <= REQ;
                    end
                end
                REQ: begin
                    if (dma_ready_i) state_r <= WAIT;
                end
                WAIT: begin
                    if (dma_done_i) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase

            if (slot_write) begin
                slot_v_r    <= 1'b1;
                slot_addr_r <= pf_addr_i;
            end else if (supersede || dequeue || age_drop) begin
                slot_v_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_streampf_dma_sched.sv
// Directed bench for streampf_dma_sched with max_wait_p=4; expectations follow STREAMPF_SCHED_AGING_EN.
module tb_streampf_dma_sched;

`ifdef STREAMPF_SCHED_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        demand_v_i;
    logic [31:0] demand_addr_i;
    logic        demand_yumi_o;
    logic        pf_v_i;
    logic [31:0] pf_addr_i;
    logic        pf_ready_o;
    logic        dma_v_o;
    logic [31:0] dma_addr_o;
    logic        dma_pf_o;
    logic        dma_ready_i;
    logic        dma_done_i;
    logic        dma_busy_o;
    logic        pf_drop_o;

    int n_cmp = 0;
    int n_err = 0;

    streampf_dma_sched #(.addr_width_p(32), .max_wait_p(4)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .demand_v_i    (demand_v_i),
        .demand_addr_i (demand_addr_i),
        .demand_yumi_o (demand_yumi_o),
        .pf_v_i        (pf_v_i),
        .pf_addr_i     (pf_addr_i),
        .pf_ready_o    (pf_ready_o),
        .dma_v_o       (dma_v_o),
        .dma_addr_o    (dma_addr_o),
        .dma_pf_o      (dma_pf_o),
        .dma_ready_i   (dma_ready_i),
        .dma_done_i    (dma_done_i),
        .dma_busy_o    (dma_busy_o),
        .pf_drop_o     (pf_drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called in a REQ cycle with dma_ready_i high; returns at the start of the next IDLE cycle.
    task automatic finish_txn();
        tick();
        dma_done_i = 1'b1;
        tick();
        dma_done_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        demand_v_i = 1'b0; demand_addr_i = '0;
        pf_v_i = 1'b0; pf_addr_i = '0;
        dma_ready_i = 1'b0; dma_done_i = 1'b0;
        tick(); tick();
        check("rst_dma_v", dma_v_o, 0);
        check("rst_busy", dma_busy_o, 0);
        check("rst_pf_ready", pf_ready_o, 1);
        check("rst_yumi", demand_yumi_o, 0);
        check("rst_drop", pf_drop_o, 0);
        check("rst_addr", dma_addr_o, 0);
        reset_i = 1'b0;

        // Demand 0x100, done three cycles after acceptance
        demand_v_i = 1'b1; demand_addr_i = 32'h100; dma_ready_i = 1'b1; #1;
        check("t1_yumi", demand_yumi_o, 1);
        check("t1_busy0", dma_busy_o, 0);
        tick(); demand_v_i = 1'b0; #1;
        check("t1_v", dma_v_o, 1);
        check("t1_addr", dma_addr_o, 32'h100);
        check("t1_pf", dma_pf_o, 0);
        check("t1_yumi_busy", demand_yumi_o, 0);
        tick(); #1;
        check("t1_wait_v", dma_v_o, 0);
        check("t1_wait_busy", dma_busy_o, 1);
        tick(); dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0; #1;
        check("t1_idle_busy", dma_busy_o, 0);

        // Prefetch 0x140 written during WAIT, issued after done
        demand_v_i = 1'b1; demand_addr_i = 32'h120;
        tick(); demand_v_i = 1'b0;
        tick();
        pf_v_i = 1'b1; pf_addr_i = 32'h140; #1;
        check("t2_ready_before", pf_ready_o, 1);
        tick(); pf_v_i = 1'b0; #1;
        check("t2_ready_held", pf_ready_o, 0);
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0; #1;
        check("t2_idle_busy", dma_busy_o, 0);
        check("t2_idle_v", dma_v_o, 0);
        tick(); #1;
        check("t2_pf_v", dma_v_o, 1);
        check("t2_pf_addr", dma_addr_o, 32'h140);
        check("t2_pf_flag", dma_pf_o, 1);
        check("t2_ready_after", pf_ready_o, 1);
        finish_txn();

        // Slot 0x180 vs demand 0x200 in the same IDLE cycle
        pf_v_i = 1'b1; pf_addr_i = 32'h180;
        tick(); pf_v_i = 1'b0;
        demand_v_i = 1'b1; demand_addr_i = 32'h200; #1;
        check("t3_yumi", demand_yumi_o, 1);
        check("t3_no_drop", pf_drop_o, 0);
        tick(); demand_v_i = 1'b0; #1;
        check("t3_dem_v", dma_v_o, 1);
        check("t3_dem_addr", dma_addr_o, 32'h200);
        check("t3_dem_pf", dma_pf_o, 0);
        check("t3_slot_kept", pf_ready_o, 0);
        finish_txn(); #1;
        check("t3_idle_v", dma_v_o, 0);
        tick(); #1;
        check("t3_pf_v", dma_v_o, 1);
        check("t3_pf_addr", dma_addr_o, 32'h180);
        check("t3_pf_flag", dma_pf_o, 1);
        finish_txn();

        // Matching demand supersedes the buffered prefetch
        pf_v_i = 1'b1; pf_addr_i = 32'h1C0;
        tick(); pf_v_i = 1'b0;
        demand_v_i = 1'b1; demand_addr_i = 32'h1C0; #1;
        check("t4_yumi", demand_yumi_o, 1);
        check("t4_drop", pf_drop_o, 1);
        tick(); demand_v_i = 1'b0; #1;
        check("t4_drop_once", pf_drop_o, 0);
        check("t4_slot_empty", pf_ready_o, 1);
        check("t4_v", dma_v_o, 1);
        check("t4_addr", dma_addr_o, 32'h1C0);
        check("t4_pf", dma_pf_o, 0);
        finish_txn(); #1;
        check("t4_idle_v", dma_v_o, 0);
        tick(); #1;
        check("t4_no_second_v", dma_v_o, 0);
        check("t4_no_second_busy", dma_busy_o, 0);

        // Prefetch 0x280 held in WAIT for ten cycles
        demand_v_i = 1'b1; demand_addr_i = 32'h240;
        tick(); demand_v_i = 1'b0;
        tick();
        pf_v_i = 1'b1; pf_addr_i = 32'h280;
        tick(); pf_v_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            #1;
            check($sformatf("t5_drop_c%0d", i), pf_drop_o, (AGING && i == 4) ? 1 : 0);
            tick();
        end
        check("t5_ready_end", pf_ready_o, AGING ? 1 : 0);
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        tick(); #1;
        check("t5_v", dma_v_o, AGING ? 0 : 1);
        check("t5_addr", dma_v_o ? dma_addr_o : 32'h0, AGING ? 32'h0 : 32'h280);
        check("t5_pf", dma_v_o ? 32'(dma_pf_o) : 32'h0, AGING ? 0 : 1);
        if (!AGING) finish_txn();

        // Stall in REQ for five cycles, then reset mid-transaction
        dma_ready_i = 1'b0;
        demand_v_i = 1'b1; demand_addr_i = 32'h300;
        tick(); demand_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t6_stall_v%0d", i), dma_v_o, 1);
            check($sformatf("t6_stall_addr%0d", i), dma_addr_o, 32'h300);
            if (i == 4) begin
                pf_v_i = 1'b1; pf_addr_i = 32'h340;
            end
            tick();
        end
        pf_v_i = 1'b0; #1;
        check("t6_slot_full", pf_ready_o, 0);
        check("t6_still_v", dma_v_o, 1);
        reset_i = 1'b1; #1;
        check("t6_rst_v", dma_v_o, 0);
        check("t6_rst_busy", dma_busy_o, 0);
        check("t6_rst_ready", pf_ready_o, 1);
        check("t6_rst_addr", dma_addr_o, 0);
        check("t6_rst_pf", dma_pf_o, 0);
        check("t6_rst_drop", pf_drop_o, 0);
        check("t6_rst_yumi", demand_yumi_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
